// File: rtl/spi_frame_reader_if.sv
// rtl/spi_frame_reader_if.sv - SPI pin bundle between the frame reader (master) and the measurement slave
interface spi_frame_reader_if;
  logic sck;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output sck, output cs, output mosi, input miso);
  modport slave  (input sck, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_frame_reader.sv
// rtl/spi_frame_reader.sv - SPI master reading the 192-bit converter result frame
// Optional SPI_RD_CHECK_EN adds frame_err, flagging nonzero reserved bits.
module spi_frame_reader #(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  spi_frame_reader_if.master   spi,
`ifdef SPI_RD_CHECK_EN
  output logic                 frame_err,
`endif
  output logic [31:0]          stpwmNA,
  output logic [31:0]          stpwmNB,
  output logic [31:0]          stpwmPA,
  output logic [31:0]          stpwmPB,
  output logic [11:0]          strundown,
  output logic [7:0]           stN64,
  output logic [7:0]           stP8,
  output logic [7:0]           stN1
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0] FRAME_BITS = 8'd192;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_HI, S_PRE_LO, S_SETUP, S_SCK_HI, S_SCK_LO, S_DONE
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       bit_cnt;
  logic [191:0]     shifter;
  logic             sck_q;
  logic             cs_q;
  logic             tick;

  assign tick     = (div_cnt == DIV_LAST);
  assign spi.sck  = sck_q;
  assign spi.cs   = cs_q;
  assign spi.mosi = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shifter   <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      stpwmNA   <= '0;
      stpwmNB   <= '0;
      stpwmPA   <= '0;
      stpwmPB   <= '0;
      strundown <= '0;
      stN64     <= '0;
      stP8      <= '0;
      stN1      <= '0;
`ifdef SPI_RD_CHECK_EN
      frame_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state != S_IDLE && state != S_DONE)
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_PRE_HI;
            sck_q   <= 1'b1;
            busy    <= 1'b1;
            div_cnt <= '0;
          end
        end
        // Preload pulse with cs high makes the slave latch word 0.
        S_PRE_HI: if (tick) begin
          state <= S_PRE_LO;
          sck_q <= 1'b0;
        end
        S_PRE_LO: if (tick) begin
          state <= S_SETUP;
          cs_q  <= 1'b0;
        end
        S_SETUP: if (tick) begin
          state <= S_SCK_HI;
          sck_q <= 1'b1;
        end
        S_SCK_HI: if (tick) begin
          state   <= S_SCK_LO;
          sck_q   <= 1'b0;
          shifter <= {shifter[190:0], spi.miso};
          bit_cnt <= bit_cnt + 8'd1;
        end
        S_SCK_LO: if (tick) begin
          if (bit_cnt == FRAME_BITS) begin
            state     <= S_DONE;
            cs_q      <= 1'b1;
            done      <= 1'b1;
            stpwmNA   <= shifter[191:160];
            stpwmNB   <= shifter[159:128];
            stpwmPA   <= shifter[127:96];
            stpwmPB   <= shifter[95:64];
            strundown <= shifter[59:48];
            stN64     <= shifter[47:40];
            stP8      <= shifter[39:32];
            stN1      <= shifter[31:24];
`ifdef SPI_RD_CHECK_EN
            frame_err <= (shifter[63:60] != 4'h0) || (shifter[23:0] != 24'h0);
`endif
          end else begin
            state <= S_SCK_HI;
            sck_q <= 1'b1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          bit_cnt <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_reader.sv
// tb/tb_spi_frame_reader.sv - directed bench for spi_frame_reader with a behavioural slave per DUT
module tb_spi_frame_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, start_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  spi_frame_reader_if a_if ();
  spi_frame_reader_if b_if ();

  logic        a_busy, a_done, b_busy, b_done;
  logic [31:0] a_na, a_nb, a_pa, a_pb, b_na, b_nb, b_pa, b_pb;
  logic [11:0] a_rd, b_rd;
  logic [7:0]  a_n64, a_p8, a_n1, b_n64, b_p8, b_n1;
`ifdef SPI_RD_CHECK_EN
  logic        a_err, b_err;
`endif

  spi_frame_reader #(.CLK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(a_busy), .done(a_done), .spi(a_if),
`ifdef SPI_RD_CHECK_EN
    .frame_err(a_err),
`endif
    .stpwmNA(a_na), .stpwmNB(a_nb), .stpwmPA(a_pa), .stpwmPB(a_pb),
    .strundown(a_rd), .stN64(a_n64), .stP8(a_p8), .stN1(a_n1)
  );

  spi_frame_reader #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(b_busy), .done(b_done), .spi(b_if),
`ifdef SPI_RD_CHECK_EN
    .frame_err(b_err),
`endif
    .stpwmNA(b_na), .stpwmNB(b_nb), .stpwmPA(b_pa), .stpwmPB(b_pb),
    .strundown(b_rd), .stN64(b_n64), .stP8(b_p8), .stN1(b_n1)
  );

  // Slave: latch frame on a preload edge, then shift one bit out per rising edge.
  logic [191:0] slave_frame;
  logic [191:0] a_sr = '0, b_sr = '0;
  logic         a_miso = 1'b0, b_miso = 1'b0;
  int           a_pre = 0, a_dat = 0, b_pre = 0, b_dat = 0, a_dcnt = 0;
  assign a_if.miso = a_miso;
  assign b_if.miso = b_miso;

  always @(posedge a_if.sck) begin
    if (a_if.cs) begin
      a_sr  <= slave_frame;
      a_pre <= a_pre + 1;
    end else begin
      a_miso <= a_sr[191];
      a_sr   <= {a_sr[190:0], 1'b0};
      a_dat  <= a_dat + 1;
    end
  end

  always @(posedge b_if.sck) begin
    if (b_if.cs) begin
      b_sr  <= slave_frame;
      b_pre <= b_pre + 1;
    end else begin
      b_miso <= b_sr[191];
      b_sr   <= {b_sr[190:0], 1'b0};
      b_dat  <= b_dat + 1;
    end
  end

  always @(posedge clk) if (a_done) a_dcnt <= a_dcnt + 1;

  function automatic logic [191:0] build_frame(
    input logic [31:0] na, input logic [31:0] nb, input logic [31:0] pa, input logic [31:0] pb,
    input logic [11:0] rd, input logic [7:0] n64, input logic [7:0] p8, input logic [7:0] n1,
    input logic [23:0] lo);
    return {na, nb, pa, pb, 4'h0, rd, n64, p8, n1, lo};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int sel, input logic [191:0] f);
    check({tag, ".na"},  sel ? b_na  : a_na,  f[191:160]);
    check({tag, ".nb"},  sel ? b_nb  : a_nb,  f[159:128]);
    check({tag, ".pa"},  sel ? b_pa  : a_pa,  f[127:96]);
    check({tag, ".pb"},  sel ? b_pb  : a_pb,  f[95:64]);
    check({tag, ".rd"},  sel ? b_rd  : a_rd,  f[59:48]);
    check({tag, ".n64"}, sel ? b_n64 : a_n64, f[47:40]);
    check({tag, ".p8"},  sel ? b_p8  : a_p8,  f[39:32]);
    check({tag, ".n1"},  sel ? b_n1  : a_n1,  f[31:24]);
  endtask

  task automatic start_frame(input int sel, output int n0);
    @(negedge clk);
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    n0 = cyc;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Returns cycles from the negedge before the start edge to the done cycle, -1 on timeout.
  task automatic wait_done(input int sel, input int n0, output int lat);
    lat = -1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if ((sel != 0) ? b_done : a_done) begin
        lat = cyc - n0;
        break;
      end
    end
  endtask

  task automatic wait_bits(input int snap, input int nbits);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (a_dat - snap >= nbits) break;
    end
  endtask

  logic [191:0] nom, ones, dead;
  int n0, lat, pre0, dat0, dc0;

  initial begin
    nom  = build_frame(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0,
                       12'hABC, 8'h5A, 8'hA5, 8'h3C, 24'h0);
    ones = '1;
    dead = build_frame(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                       12'h123, 8'h45, 8'h67, 8'h89, 24'h0);
    slave_frame = nom;
    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);

    check("rst.cs", a_if.cs, 1'b1);
    check("rst.sck", a_if.sck, 1'b0);
    check("rst.mosi", a_if.mosi, 1'b0);
    check("rst.busy", a_busy, 1'b0);
    check("rst.done", a_done, 1'b0);
    check_out("rst", 0, '0);
    check("rst.b_cs", b_if.cs, 1'b1);
    rst_n = 1'b1;

    // Nominal frame
    pre0 = a_pre; dat0 = a_dat;
    start_frame(0, n0);
    wait_done(0, n0, lat);
    check("nom.latency", lat, 1549);
    check("nom.busy_at_done", a_busy, 1'b1);
    check("nom.cs_at_done", a_if.cs, 1'b1);
    check_out("nom", 0, nom);
    check("nom.preload_edges", a_pre - pre0, 1);
    check("nom.data_edges", a_dat - dat0, 192);
    @(negedge clk);
    check("nom.done_pulse", a_done, 1'b0);
    check("nom.busy_fall", a_busy, 1'b0);

    // Extra start mid-frame is ignored
    dc0 = a_dcnt; dat0 = a_dat;
    slave_frame = dead;
    start_frame(0, n0);
    wait_bits(dat0, 50);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, n0, lat);
    check("ign.latency", lat, 1549);
    check_out("ign", 0, dead);
    repeat (1700) @(negedge clk);
    check("ign.done_count", a_dcnt - dc0, 1);
    check("ign.busy", a_busy, 1'b0);

    // start held high: back-to-back frames
    slave_frame = nom;
    @(negedge clk);
    start_a = 1'b1;
    n0 = cyc;
    wait_done(0, n0, lat);
    check("b2b1.latency", lat, 1549);
    check_out("b2b1", 0, nom);
    slave_frame = ones;
    n0 = cyc;
    wait_done(0, n0, lat);
    start_a = 1'b0;
    check("b2b2.gap", lat, 1550);
    check_out("b2b2", 0, ones);
    repeat (3) @(negedge clk);
    check("b2b.idle", a_busy, 1'b0);

    // Reset at bit 100
    slave_frame = nom;
    dat0 = a_dat;
    start_frame(0, n0);
    wait_bits(dat0, 100);
    rst_n = 1'b0;
    #1;
    check("rstmid.cs", a_if.cs, 1'b1);
    check("rstmid.sck", a_if.sck, 1'b0);
    check("rstmid.busy", a_busy, 1'b0);
    check_out("rstmid", 0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    slave_frame = dead;
    start_frame(0, n0);
    wait_done(0, n0, lat);
    check("resync.latency", lat, 1549);
    check_out("resync", 0, dead);

    // CLK_DIV = 1
    slave_frame = nom;
    pre0 = b_pre; dat0 = b_dat;
    start_frame(1, n0);
    wait_done(1, n0, lat);
    check("div1.latency", lat, 388);
    check_out("div1", 1, nom);
    check("div1.preload_edges", b_pre - pre0, 1);
    check("div1.data_edges", b_dat - dat0, 192);

`ifdef SPI_RD_CHECK_EN
    slave_frame = build_frame(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0,
                              12'hABC, 8'h5A, 8'hA5, 8'h3C, 24'h000001);
    start_frame(0, n0);
    wait_done(0, n0, lat);
    check("chk.err_set", a_err, 1'b1);
    check("chk.n1", a_n1, 8'h3C);
    slave_frame = nom;
    start_frame(0, n0);
    wait_done(0, n0, lat);
    check("chk.err_clr", a_err, 1'b0);
    check_out("chk", 0, nom);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_frame_reader.md
# spi_frame_reader

- SPI master that reads the converter's 192-bit result frame from the measurement SPI slave.
- Generates `sck` and `cs`, performs the preload clock the slave requires, and deserialises six MSB-first 32-bit words.
- Presents the decoded fields (PWM counts, rundown, N64/P8/N1 counts) atomically with a one-cycle `done` strobe.
- Sits in the host-side FPGA/controller logic, between the slave's pins and the result-processing logic.

## Interface
Parameters:
- `CLK_DIV`, 4, `clk` cycles per `sck` half-period; legal range ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1 system clock
- `rst_n` input 1 asynchronous active-low reset
- `start` input 1 request one frame read; sampled only in IDLE
- `busy` output 1 high while a frame is in progress
- `done` output 1 one-cycle pulse when the outputs below update
- `sck` output 1 SPI clock, idle low
- `cs` output 1 slave select, active low, idle high
- `mosi` output 1 constant 0 (slave ignores it)
- `miso` input 1 slave data out
- `stpwmNA`, `stpwmNB`, `stpwmPA`, `stpwmPB` output 32 each, PWM counts, words 0–3
- `strundown` output 12 rundown count
- `stN64`, `stP8`, `stN1` output 8 each, slope counts

## Operation
- Frame format, MSB first, 6×32 bits:
  - words 0–3: NA, NB, PA, PB
  - word 4: {4'b0, rundown[11:0], N64[7:0], P8[7:0]}
  - word 5: {N1[7:0], 24'b0}
- Slave protocol:
  - slave loads word 0 on any `sck` rising edge with `cs` high
  - with `cs` low, slave drives bit k (k=0..191) on the k+1-th rising edge
  - master samples each bit when it drives `sck` low
- States:
  - IDLE: `cs`=1, `sck`=0; `start`=1 → PRE_HI.
  - PRE_HI (`cs`=1, `sck`=1, CLK_DIV cycles) → PRE_LO.
  - PRE_LO (`cs`=1, `sck`=0, CLK_DIV cycles) → SETUP.
  - SETUP: `cs`=0, `sck`=0 for CLK_DIV cycles → SCK_HI.
  - SCK_HI: `sck`=1 for CLK_DIV cycles. On the exit edge: drive `sck` low, shift `miso` into the receive shifter, increment bit counter (8 bits, 0..192) → SCK_LO.
  - SCK_LO: CLK_DIV cycles, then:
    - counter = 192 → DONE;
    - otherwise → SCK_HI.
  - DONE: `cs`=1; all outputs load from the shifter simultaneously; `done`=1 for this cycle → IDLE.
- Outputs hold their last frame until the next DONE; a partial frame never reaches them.
- `start` in any state other than IDLE is ignored, with no queuing. `start` held high → back-to-back frames, separated by DONE plus one IDLE cycle.
- `busy` = state ≠ IDLE.

## Timing
- Reset values:
  - `cs`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0
  - all data outputs 0; state IDLE; counters 0
- Reset mid-frame: the above values apply immediately and asynchronously; the frame is discarded and the outputs are zeroed. The slave resynchronises on the next frame's preload pulse.
- `start` sampled at edge T:
  - `busy` rises at T+1
  - `done` is high during cycle T+1+387·CLK_DIV
  - `busy` falls one cycle later
- `sck` period is 2·CLK_DIV cycles at 50% duty. `miso` is sampled CLK_DIV cycles after the corresponding rising edge.
- Bit counter never wraps; exactly 192 rising edges occur with `cs` low.

## Configuration
- `SPI_RD_CHECK_EN` defined:
  - adds output `frame_err` (1 bit, reset 0), updated at DONE
  - `frame_err` is 1 if word4[31:28] or word5[23:0] is nonzero, else 0
  - data outputs update regardless
- `SPI_RD_CHECK_EN` undefined: no `frame_err` port; reserved bits are discarded unchecked.

## Test plan
- Reset: assert `rst_n`=0 → `cs`=1, `sck`=0, `busy`=0, `done`=0, all data outputs 0.
- Nominal frame against a bench slave model (CLK_DIV=4):
  - slave values: NA=0x12345678, NB=0x9ABCDEF0, PA=0x0F0F0F0F, PB=0xF0F0F0F0, rundown=0xABC, N64=0x5A, P8=0xA5, N1=0x3C
  - required: outputs equal these values, `done` at T+1549, exactly one preload rising edge with `cs`=1, 192 rising edges with `cs`=0.
- `start` pulsed again at bit 50 → ignored, one frame only. `start` held high → two frames, second with all-ones data, each correct.
- Reset at bit 100 → `cs`=1 and `sck`=0 immediately, outputs 0. The next frame reads 0xDEADBEEF in all four PWM words.
- CLK_DIV=1 → nominal frame correct, `done` at T+388.
- `SPI_RD_CHECK_EN` defined:
  - slave sends word5 = 0x3C000001 → `frame_err`=1, `stN1`=0x3C
  - clean frame → `frame_err`=0
